// File: rtl/cap_sensor_pkg.sv
// ---------------------------------------------------------------------------
// cap_sensor_pkg
//
// Shared constants, the scanner state type and the reading filter helper
// for the capacitive sensor scanner.
//
// Contents:
//   NUM_PADS       number of sensor pads scanned per sweep
//   READING_W      width of a charge count / stored reading
//   SEL_W          width of the pad select index
//   scan_state_t   DISCHARGE / CHARGE / STORE scanner states
//   blend_reading  (3*old + new) >> 2 smoothing, evaluated at READING_W+2 bits
// ---------------------------------------------------------------------------
package cap_sensor_pkg;

    localparam int NUM_PADS  = 9;
    localparam int READING_W = 32;
    localparam int SEL_W     = 4;

    typedef enum logic [1:0] {
        DISCHARGE = 2'd0,
        CHARGE    = 2'd1,
        STORE     = 2'd2
    } scan_state_t;

    // Two extra bits hold 3*old + new without overflow; the result is
    // truncated back to the reading width after the divide-by-four.
    function automatic logic [READING_W-1:0] blend_reading(
        input logic [READING_W-1:0] old_val,
        input logic [READING_W-1:0] new_val
    );
        logic [READING_W+1:0] sum;
        sum = ({2'b00, old_val} * (READING_W+2)'(3)) + {2'b00, new_val};
        return sum[READING_W+1:2];
    endfunction

endpackage

// File: rtl/pad_synchronizer.sv
// ---------------------------------------------------------------------------
// pad_synchronizer
//
// Two-stage synchronizer bringing the raw, asynchronous pad levels into the
// clock domain. Both stages clear to 0 on reset.
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   async_in  in   [WIDTH-1:0] raw pad levels
//   sync_out  out  [WIDTH-1:0] synchronized pad levels (two cycles late)
// ---------------------------------------------------------------------------
module pad_synchronizer
    import cap_sensor_pkg::*;
#(
    parameter int WIDTH = NUM_PADS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] stage1;

    // First stage may go metastable; only the second stage is used.
    always_ff @(posedge clock) begin
        if (reset) begin
            stage1   <= '0;
            sync_out <= '0;
        end else begin
            stage1   <= async_in;
            sync_out <= stage1;
        end
    end

endmodule

// File: rtl/cap_sensor_scanner.sv
// ---------------------------------------------------------------------------
// cap_sensor_scanner
//
// Scans nine capacitive pads in order 0..8. For each pad the open-drain
// driver first holds the pad low for DISCHARGE_CYCLES cycles, then releases
// it and counts cycles until the synchronized pad level reads high (or the
// count reaches TIMEOUT). The count is stored into that pad's reading slot
// and the scanner moves on to the next pad. scan_done pulses for one cycle
// after pad 8 has been stored.
//
// Build option:
//   CAP_SENSOR_FILTER_EN  when defined, each store writes (3*old + new) >> 2
//                         instead of the raw count.
//
// Parameters:
//   DISCHARGE_CYCLES  cycles the selected pad is held low before charging
//   TIMEOUT           saturation value of the charge count (<= 2^32-1)
//
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   synchronous active-high reset
//   scan_en          in   1 = scanning runs, 0 = park in DISCHARGE
//   pad_in           in   [8:0] raw pad levels
//   pad_drive_low    out  [8:0] 1 = pad pulled low, 0 = released
//   sensor_readings  out  [287:0] pad i reading in bits [32*i+31:32*i]
//   scan_done        out  one-cycle pulse after each complete sweep
// ---------------------------------------------------------------------------
module cap_sensor_scanner
    import cap_sensor_pkg::*;
#(
    parameter int unsigned DISCHARGE_CYCLES = 1000,
    parameter int unsigned TIMEOUT          = 65535
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            scan_en,
    input  logic [NUM_PADS-1:0]             pad_in,
    output logic [NUM_PADS-1:0]             pad_drive_low,
    output logic [NUM_PADS*READING_W-1:0]   sensor_readings,
    output logic                            scan_done
);

    localparam logic [READING_W-1:0] TIMEOUT_VAL = READING_W'(TIMEOUT);
    localparam logic [READING_W-1:0] DISC_LAST   =
        (DISCHARGE_CYCLES == 0) ? READING_W'(0) : READING_W'(DISCHARGE_CYCLES - 1);
    localparam logic [SEL_W-1:0]     SEL_LAST    = SEL_W'(NUM_PADS - 1);

    scan_state_t                          state;
    scan_state_t                          state_next;
    logic [SEL_W-1:0]                     sel;
    logic [SEL_W-1:0]                     sel_next;
    logic [READING_W-1:0]                 disc_count;
    logic [READING_W-1:0]                 disc_count_next;
    logic [READING_W-1:0]                 charge_count;
    logic [READING_W-1:0]                 charge_count_next;
    logic                                 store_en;
    logic                                 scan_done_next;
    logic [READING_W-1:0]                 store_value;
    logic [NUM_PADS-1:0][READING_W-1:0]   readings;
    logic [NUM_PADS-1:0]                  sync_in;
    logic                                 pad_level;

    pad_synchronizer #(
        .WIDTH    (NUM_PADS)
    ) u_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (pad_in),
        .sync_out (sync_in)
    );

    assign pad_level       = sync_in[sel];
    assign sensor_readings = readings;

`ifdef CAP_SENSOR_FILTER_EN
    assign store_value = blend_reading(readings[sel], charge_count);
`else
    assign store_value = charge_count;
`endif

    // Next-state logic. Dropping scan_en parks the scanner in DISCHARGE on
    // the current pad with the discharge count cleared, so a measurement cut
    // short restarts from a full discharge and nothing is stored.
    always_comb begin
        state_next        = state;
        sel_next          = sel;
        disc_count_next   = disc_count;
        charge_count_next = charge_count;
        store_en          = 1'b0;
        scan_done_next    = 1'b0;

        if (!scan_en) begin
            state_next      = DISCHARGE;
            disc_count_next = '0;
        end else begin
            case (state)
                DISCHARGE: begin
                    if (disc_count == DISC_LAST) begin
                        state_next        = CHARGE;
                        disc_count_next   = '0;
                        charge_count_next = '0;
                    end else begin
                        disc_count_next = disc_count + READING_W'(1);
                    end
                end
                CHARGE: begin
                    // The count only advances while below TIMEOUT, so it
                    // saturates there instead of wrapping.
                    if (pad_level || (charge_count == TIMEOUT_VAL)) begin
                        state_next = STORE;
                    end else begin
                        charge_count_next = charge_count + READING_W'(1);
                    end
                end
                STORE: begin
                    store_en        = 1'b1;
                    scan_done_next  = (sel == SEL_LAST);
                    sel_next        = (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);
                    state_next      = DISCHARGE;
                    disc_count_next = '0;
                end
                default: begin
                    state_next      = DISCHARGE;
                    disc_count_next = '0;
                end
            endcase
        end
    end

    // Only the selected pad is ever released, and only while charging.
    always_comb begin
        pad_drive_low = '1;
        if (state == CHARGE) begin
            pad_drive_low[sel] = 1'b0;
        end
    end

    // Scanner state and counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= DISCHARGE;
            sel          <= '0;
            disc_count   <= '0;
            charge_count <= '0;
            scan_done    <= 1'b0;
        end else begin
            state        <= state_next;
            sel          <= sel_next;
            disc_count   <= disc_count_next;
            charge_count <= charge_count_next;
            scan_done    <= scan_done_next;
        end
    end

    // Reading bank: one slot written per STORE; reset wins over a store
    // landing on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            readings <= '0;
        end else if (store_en) begin
            readings[sel] <= store_value;
        end
    end

endmodule

// File: tb/tb_cap_sensor_scanner.sv
// ---------------------------------------------------------------------------
// tb_cap_sensor_scanner
//
// Self-checking bench for cap_sensor_scanner (DISCHARGE_CYCLES=4,
// TIMEOUT=100). Each pad is emulated as either shorted high, shorted low,
// or an RC pad that reads high a chosen number of cycles after its driver
// releases it. For every sweep the expected slot contents and sweep length
// are computed from those pad models and queued; a monitor pops an entry
// on every scan_done pulse and compares. Honours CAP_SENSOR_FILTER_EN.
// ---------------------------------------------------------------------------
module tb_cap_sensor_scanner;

    localparam int unsigned DISC = 4;
    localparam int unsigned TMO  = 100;
    localparam int          NP   = 9;
    localparam int          RW   = 288;

    typedef enum logic [1:0] {PAD_HIGH, PAD_LOW, PAD_RC} pad_mode_e;

    typedef struct packed {
        logic [RW-1:0] slots;
        logic [31:0]   period;
        logic          period_valid;
    } sweep_exp_t;

    logic            clock;
    logic            reset;
    logic            scan_en;
    logic [NP-1:0]   pad_in;
    logic [NP-1:0]   pad_drive_low;
    logic [RW-1:0]   sensor_readings;
    logic            scan_done;

    pad_mode_e       mode [NP];
    int              tau [NP];
    int              rel [NP];
    logic [31:0]     model_slot [NP];
    sweep_exp_t      exp_q [$];

    int              checks;
    int              passes;
    int              cyc;
    int              last_pulse;
    bit              have_prev;
    logic [RW-1:0]   prev_readings;

    cap_sensor_scanner #(
        .DISCHARGE_CYCLES (DISC),
        .TIMEOUT          (TMO)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .scan_en          (scan_en),
        .pad_in           (pad_in),
        .pad_drive_low    (pad_drive_low),
        .sensor_readings  (sensor_readings),
        .scan_done        (scan_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic finishBench();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    endtask

    task automatic checkOutput(input string name, input logic [RW-1:0] actual,
                               input logic [RW-1:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        $display("[TB] FAIL %s: wait bound expired, got timeout, expected event", name);
        finishBench();
    endtask

    // A pad reads high this many counts after release: the rise needs two
    // synchronizer stages before the scanner can see it, each costing a count.
    function automatic longint unsigned rawCount(input pad_mode_e m, input int t);
        longint unsigned c;
        case (m)
            PAD_HIGH: c = 0;
            PAD_LOW:  c = TMO;
            default: begin
                c = longint'(t) + 2;
                if (c > TMO) c = TMO;
            end
        endcase
        return c;
    endfunction

    // Physical pad emulation, updated away from the active edge.
    always @(negedge clock) begin
        for (int i = 0; i < NP; i++) begin
            if (pad_drive_low[i] !== 1'b0) rel[i] = 0;
            else rel[i] = rel[i] + 1;
            case (mode[i])
                PAD_HIGH: pad_in[i] = 1'b1;
                PAD_LOW:  pad_in[i] = 1'b0;
                default:  pad_in[i] = (pad_drive_low[i] === 1'b0) && (rel[i] > tau[i]);
            endcase
        end
    end

    task automatic randomizeModes();
        for (int i = 0; i < NP; i++) begin
            int r;
            r = int'($urandom_range(0, 7));
            if (r < 2) mode[i] = PAD_HIGH;
            else if (r == 2) mode[i] = PAD_LOW;
            else if (r == 3) begin mode[i] = PAD_RC; tau[i] = int'($urandom_range(95, 99)); end
            else begin mode[i] = PAD_RC; tau[i] = int'($urandom_range(0, 30)); end
        end
    endtask

    // Queue what the coming sweep must leave in the slots and how long it takes.
    task automatic applyStimulus(input bit period_valid);
        sweep_exp_t e;
        longint unsigned raw;
        longint unsigned total;
        e.slots = '0;
        total = 0;
        for (int i = 0; i < NP; i++) begin
            raw = rawCount(mode[i], tau[i]);
`ifdef CAP_SENSOR_FILTER_EN
            model_slot[i] = 32'((longint'(model_slot[i]) * 3 + raw) / 4);
`else
            model_slot[i] = 32'(raw);
`endif
            total += DISC + raw + 2;
            e.slots[i*32 +: 32] = model_slot[i];
        end
        e.period = 32'(total);
        e.period_valid = period_valid;
        exp_q.push_back(e);
    endtask

    task automatic waitSweep();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (scan_done !== 1'b1 && n < 5000);
        if (scan_done !== 1'b1) timeoutFail("scan_done_wait");
    endtask

    // Monitor: every slot change must carry the value queued for this sweep,
    // at most one pad may be released, and each scan_done closes a sweep.
    always @(negedge clock) begin
        sweep_exp_t head;
        cyc++;
        if (reset === 1'b1) begin
            have_prev = 1'b0;
        end else begin
            checkOutput("drive_one_released", RW'($countones(~pad_drive_low) <= 1), RW'(1));
            for (int j = 0; j < NP; j++) begin
                if (sensor_readings[j*32 +: 32] !== prev_readings[j*32 +: 32]) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("slot_write_unexpected", RW'(j), RW'(-1));
                    end else begin
                        head = exp_q[0];
                        checkOutput("slot_write", RW'(sensor_readings[j*32 +: 32]),
                                    RW'(head.slots[j*32 +: 32]));
                    end
                end
            end
            if (scan_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput("scan_done_unexpected", RW'(1), RW'(0));
                end else begin
                    head = exp_q.pop_front();
                    checkOutput("sweep_readings", sensor_readings, head.slots);
                    if (have_prev && head.period_valid)
                        checkOutput("sweep_period", RW'(cyc - last_pulse), RW'(head.period));
                end
                have_prev  = 1'b1;
                last_pulse = cyc;
            end
        end
        prev_readings = sensor_readings;
    end

    // scan_en dropped mid-charge of pad 2, then restored.
    task automatic scanEnableGap();
        int n;
        randomizeModes();
        mode[0] = PAD_HIGH;
        mode[1] = PAD_HIGH;
        mode[2] = PAD_LOW;
        applyStimulus(1'b0);
        n = 0;
        while (pad_drive_low[2] !== 1'b0 && n < 200) begin @(negedge clock); n++; end
        if (pad_drive_low[2] !== 1'b0) timeoutFail("gap_release_wait");
        repeat (20) @(negedge clock);
        scan_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            checkOutput("gap_drive_all_low", RW'(pad_drive_low), RW'(9'h1FF));
        end
        scan_en = 1'b1;
        n = 0;
        do begin @(negedge clock); n++; end while (pad_drive_low[2] !== 1'b0 && n < 50);
        checkOutput("gap_restart_discharge", RW'(n), RW'(DISC));
        waitSweep();
    endtask

    // Reset landing on the STORE cycle of pad 5.
    task automatic resetOnStore();
        int n;
        int idx;
        randomizeModes();
        mode[5] = PAD_RC;
        tau[5]  = 5;
        applyStimulus(1'b1);
        waitSweep();
        randomizeModes();
        mode[5] = PAD_RC;
        tau[5]  = 3;
        applyStimulus(1'b1);
        n = 0;
        while (pad_drive_low[5] !== 1'b0 && n < 2000) begin @(negedge clock); n++; end
        if (pad_drive_low[5] !== 1'b0) timeoutFail("store5_release_wait");
        n = 0;
        while (pad_drive_low[5] !== 1'b1 && n < 200) begin @(negedge clock); n++; end
        if (pad_drive_low[5] !== 1'b1) timeoutFail("store5_end_wait");
        reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NP; i++) model_slot[i] = '0;
        @(negedge clock);
        checkOutput("store_reset_readings", sensor_readings, RW'(0));
        checkOutput("store_reset_scan_done", RW'(scan_done), RW'(0));
        checkOutput("store_reset_drive", RW'(pad_drive_low), RW'(9'h1FF));
        @(negedge clock);
        randomizeModes();
        applyStimulus(1'b1);
        reset = 1'b0;
        n = 0;
        do begin @(negedge clock); n++; end while (pad_drive_low === 9'h1FF && n < 200);
        idx = -1;
        for (int i = NP - 1; i >= 0; i--) if (pad_drive_low[i] === 1'b0) idx = i;
        checkOutput("restart_pad", RW'(idx), RW'(0));
        waitSweep();
    endtask

    initial begin
        checks  = 0;
        passes  = 0;
        cyc     = 0;
        reset   = 1'b1;
        scan_en = 1'b1;
        for (int i = 0; i < NP; i++) model_slot[i] = '0;

        randomizeModes();
        mode[0] = PAD_RC;
        tau[0]  = 10;
        mode[3] = PAD_LOW;
        applyStimulus(1'b1);
        repeat (3) @(negedge clock);
        checkOutput("reset_readings", sensor_readings, RW'(0));
        checkOutput("reset_scan_done", RW'(scan_done), RW'(0));
        checkOutput("reset_drive", RW'(pad_drive_low), RW'(9'h1FF));
        reset = 1'b0;
        waitSweep();

        for (int i = 0; i < NP; i++) mode[i] = PAD_HIGH;
        applyStimulus(1'b1);
        waitSweep();

        repeat (6) begin
            randomizeModes();
            applyStimulus(1'b1);
            waitSweep();
        end

        scanEnableGap();

        repeat (2) begin
            randomizeModes();
            applyStimulus(1'b1);
            waitSweep();
        end

        resetOnStore();

        repeat (3) begin
            randomizeModes();
            applyStimulus(1'b1);
            waitSweep();
        end

        @(negedge clock);
        finishBench();
    end

    initial begin
        #2000000;
        checks++;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        finishBench();
    end

endmodule
